// File: rtl/div_fmt_pkg.sv
// Shared Q10.10 format constants, FSM state type and token codes for the divider/root formatters.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_fmt_pkg;

  localparam int Q_INT_BITS  = 10;
  localparam int Q_FRAC_BITS = 10;
  localparam int Q_WIDTH     = Q_INT_BITS + Q_FRAC_BITS;

  // Token code for the decimal point; digits use 0-9.
  localparam logic [3:0] DP_TOKEN = 4'hA;

  typedef enum logic [1:0] {
    IDLE,
    INT_CONV,
    FRAC_CONV,
    SEND
  } state_t;

endpackage

// File: rtl/bin2bcd_iter.sv
// Iterative double-dabble: load a binary value, then one bit per step into packed BCD.
// Latency: BIN_BITS step cycles after load; done is high once every bit has been shifted in.
// Backpressure: none; steps are ignored while done is high.
module bin2bcd_iter #(
  parameter int BIN_BITS = 10,
  parameter int DIGITS   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [BIN_BITS-1:0]   bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  done
);

  localparam int CW = $clog2(BIN_BITS + 1);

  logic [BIN_BITS-1:0]          sh;
  logic [CW-1:0]                cnt;
  logic [4*DIGITS-1:0]          adj;
  logic [4*DIGITS+BIN_BITS-1:0] shifted;

  assign done = (cnt == '0);

  // Add-3 correction on every nibble that would overflow past 9 after the shift.
  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    shifted = {adj, sh} << 1;
  end

  // Load clears the BCD accumulator; each step shifts the next binary MSB in.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh  <= '0;
      bcd <= '0;
      cnt <= '0;
    end else if (load) begin
      sh  <= bin;
      bcd <= '0;
      cnt <= CW'(BIN_BITS);
    end else if (step && !done) begin
      bcd <= shifted[4*DIGITS+BIN_BITS-1:BIN_BITS];
      sh  <= shifted[BIN_BITS-1:0];
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/quotient_dec_serializer.sv
// Converts a captured Q10.10 quotient to decimal tokens (int digits, point, truncated fraction).
// Latency: SEND entered INT_BITS+FRAC_DIGITS+1 cycles after the capture edge, then one token per cycle.
// Backpressure: valid/ready; token held stable while stalled, new result edges while busy are dropped.
module quotient_dec_serializer
  import div_fmt_pkg::*;
#(
  parameter int INT_BITS    = Q_INT_BITS,
  parameter int FRAC_BITS   = Q_FRAC_BITS,
  parameter int INT_DIGITS  = 4,
  parameter int FRAC_DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          res_valid,
  input  logic [INT_BITS+FRAC_BITS-1:0] res_data,
  output logic                          dig_valid,
  output logic [3:0]                    dig_data,
  output logic                          dig_last,
  input  logic                          dig_ready,
  output logic                          busy,
  output logic                          res_drop
);

  localparam int NTOK = INT_DIGITS + FRAC_DIGITS + 1;
  localparam int KW   = $clog2(NTOK);
  localparam int FW   = (FRAC_DIGITS > 1) ? $clog2(FRAC_DIGITS) : 1;
  localparam int FXW  = FRAC_BITS + 4;

  state_t state, state_nxt;

  logic                    res_valid_q;
  logic                    res_drop_q;
  logic [FXW-1:0]          frac_acc;
  logic [FXW-1:0]          frac_x10;
  logic [3:0]              frac_digit;
  logic [FW-1:0]           frac_cnt;
  logic [4*NTOK-1:0]       tok_sr;
  logic [KW-1:0]           tok_idx;
  logic [4*INT_DIGITS-1:0] bcd;
  logic                    bcd_done;
  logic                    res_edge;
  logic                    capture;
  logic                    xfer;
  logic                    frac_last;
  logic                    tok_last;

  assign res_edge   = res_valid & ~res_valid_q;
  assign capture    = res_edge & (state == IDLE);
  assign xfer       = dig_valid & dig_ready;
  assign frac_last  = (frac_cnt == FW'(FRAC_DIGITS - 1));
  assign tok_last   = (tok_idx == KW'(NTOK - 1));
  // x10 as shift-and-add; the integer part that spills above FRAC_BITS is the next digit.
  assign frac_x10   = (frac_acc << 3) + (frac_acc << 1);
  assign frac_digit = frac_x10[FXW-1:FRAC_BITS];
  assign res_drop   = res_drop_q;

  bin2bcd_iter #(
    .BIN_BITS (INT_BITS),
    .DIGITS   (INT_DIGITS)
  ) u_bin2bcd (
    .clk  (clk),
    .rst  (rst),
    .load (capture),
    .step (state == INT_CONV),
    .bin  (res_data[INT_BITS+FRAC_BITS-1:FRAC_BITS]),
    .bcd  (bcd),
    .done (bcd_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and token-port outputs; the port only presents data in SEND.
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    dig_valid = 1'b0;
    dig_data  = '0;
    dig_last  = 1'b0;
    case (state)
      IDLE:      if (capture) state_nxt = INT_CONV;
      INT_CONV:  if (bcd_done) state_nxt = FRAC_CONV;
      FRAC_CONV: if (frac_last) state_nxt = SEND;
      SEND: begin
        dig_valid = 1'b1;
        dig_data  = tok_sr[4*NTOK-1 -: 4];
        dig_last  = tok_last;
        if (dig_ready && tok_last) state_nxt = IDLE;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  // Edge detect, drop pulse, fraction digit generation and the outgoing token shift register.
  // Fraction digits shift into the low end of tok_sr; the BCD and point are placed on the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_drop_q  <= 1'b0;
      frac_acc    <= '0;
      frac_cnt    <= '0;
      tok_sr      <= '0;
      tok_idx     <= '0;
    end else begin
      res_valid_q <= res_valid;
      res_drop_q  <= res_edge & (state != IDLE);
      if (capture) begin
        frac_acc <= FXW'(res_data[FRAC_BITS-1:0]);
        frac_cnt <= '0;
      end else if (state == FRAC_CONV) begin
        frac_acc                  <= FXW'(frac_x10[FRAC_BITS-1:0]);
        frac_cnt                  <= frac_cnt + 1'b1;
        tok_sr[4*FRAC_DIGITS-1:0] <= {tok_sr[4*FRAC_DIGITS-5:0], frac_digit};
        if (frac_last) begin
          tok_sr[4*NTOK-1:4*FRAC_DIGITS] <= {bcd, DP_TOKEN};
          tok_idx                        <= '0;
        end
      end else if (xfer) begin
        tok_sr  <= tok_sr << 4;
        tok_idx <= tok_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_quotient_dec_serializer.sv
// Bench for quotient_dec_serializer: vector table, stall/drop/reset sequences, random results vs model.
// Latency: n/a.
// Backpressure: drives dig_ready always-on, 1-0-0-1 and random patterns.
module tb_quotient_dec_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        res_valid;
  logic [19:0] res_data;
  logic        dig_valid;
  logic [3:0]  dig_data;
  logic        dig_last;
  logic        dig_ready;
  logic        busy;
  logic        res_drop;

  quotient_dec_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .res_valid (res_valid),
    .res_data  (res_data),
    .dig_valid (dig_valid),
    .dig_data  (dig_data),
    .dig_last  (dig_last),
    .dig_ready (dig_ready),
    .busy      (busy),
    .res_drop  (res_drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Monitor state (written only by the monitor process).
  int          tok_total   = 0;
  int          last_total  = 0;
  int          last_at     = 0;
  int          drop_total  = 0;
  int          valid_rise  = 0;
  logic        prev_valid  = 1'b0;
  logic [31:0] tok_acc     = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (dig_valid && !prev_valid) valid_rise = cyc;
      prev_valid = dig_valid;
      if (dig_valid && dig_ready) begin
        tok_acc = {tok_acc[27:0], dig_data};
        if (dig_last) begin
          last_at    = tok_total;
          last_total = last_total + 1;
        end
        tok_total = tok_total + 1;
      end
      if (res_drop) drop_total = drop_total + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: decimal digits straight from the Q10.10 value, fraction truncated.
  function automatic logic [31:0] model(input logic [19:0] d);
    int          ip;
    int          fp;
    int          p;
    logic [31:0] r;
    ip = int'(d[19:10]);
    fp = int'(d[9:0]);
    r[31:28] = 4'(ip / 1000);
    r[27:24] = 4'((ip / 100) % 10);
    r[23:20] = 4'((ip / 10) % 10);
    r[19:16] = 4'(ip % 10);
    r[15:12] = 4'hA;
    p = 1;
    for (int j = 0; j < 3; j++) begin
      p = p * 10;
      r[11-4*j -: 4] = 4'(((fp * p) / 1024) % 10);
    end
    return r;
  endfunction

  function automatic logic ready_for(input int mode, input int i);
    case (mode)
      0:       return 1'b1;
      1:       return (i % 4 == 0) || (i % 4 == 3);
      default: return ($urandom_range(0, 3) != 0);
    endcase
  endfunction

  // Raise res_valid for 'hold' cycles, optionally pulse a second edge once 'drop_at'
  // tokens of this result have transferred, and collect the whole token stream.
  task automatic run_result(input string tag, input logic [19:0] d, input int mode, input int hold,
                            input int drop_at, output logic [31:0] toks, output int ntok,
                            output int last_idx, output int lat, output int drops);
    int   tok_base, last_base, drop_base, raise_cyc, pulse_i;
    int   i;
    bit   pulsed, done;
    logic pre_v, pre_r, pre_l;
    logic [3:0] pre_d;
    tok_base  = tok_total;
    last_base = last_total;
    drop_base = drop_total;
    pulsed    = 0;
    pulse_i   = 0;
    done      = 0;
    res_data  = d;
    res_valid = 1'b1;
    raise_cyc = cyc;
    i = 0;
    while (i < 400 && !done) begin
      if (i == hold) res_valid = 1'b0;
      if (drop_at >= 0 && !pulsed && i > hold && (tok_total - tok_base) == drop_at) begin
        res_valid = 1'b1;
        pulsed    = 1;
        pulse_i   = i;
      end else if (pulsed && i == pulse_i + 1) begin
        res_valid = 1'b0;
      end
      dig_ready = ready_for(mode, i);
      pre_v = dig_valid;
      pre_r = dig_ready;
      pre_d = dig_data;
      pre_l = dig_last;
      tick();
      i++;
      if (pre_v && !pre_r) begin
        check({tag, " stall_valid"}, 32'(dig_valid), 32'd1);
        check({tag, " stall_data"},  32'(dig_data),  32'(pre_d));
        check({tag, " stall_last"},  32'(dig_last),  32'(pre_l));
      end
      if (last_total > last_base) done = 1;
    end
    res_valid = 1'b0;
    dig_ready = 1'b1;
    check({tag, " timeout"}, 32'(done), 32'd1);
    toks     = tok_acc;
    ntok     = tok_total - tok_base;
    last_idx = last_at - tok_base;
    lat      = valid_rise - raise_cyc;
    drops    = drop_total - drop_base;
  endtask

  typedef struct {
    logic [19:0] data;
    int          mode;
    logic [31:0] exp;
  } vec_t;

  vec_t        vt[4];
  logic [31:0] toks;
  int          ntok, last_idx, lat, drops;
  logic [19:0] rd;

  initial begin
    vt[0] = '{data: 20'h00C00, mode: 0, exp: 32'h0003A000};
    vt[1] = '{data: 20'h53555, mode: 0, exp: 32'h0333A333};
    vt[2] = '{data: 20'hFFFFF, mode: 0, exp: 32'h1023A999};
    vt[3] = '{data: 20'h00A00, mode: 1, exp: 32'h0002A500};

    rst       = 1'b1;
    res_valid = 1'b0;
    res_data  = '0;
    dig_ready = 1'b0;
    repeat (3) tick();
    check("rst dig_valid", 32'(dig_valid), 32'd0);
    check("rst busy",      32'(busy),      32'd0);
    check("rst dig_last",  32'(dig_last),  32'd0);
    check("rst res_drop",  32'(res_drop),  32'd0);
    check("rst dig_data",  32'(dig_data),  32'd0);
    rst       = 1'b0;
    dig_ready = 1'b1;
    tick();

    // Directed vectors.
    for (int v = 0; v < 4; v++) begin
      run_result($sformatf("vec%0d", v), vt[v].data, vt[v].mode, 1, -1, toks, ntok, last_idx, lat, drops);
      check($sformatf("vec%0d tokens", v),   toks,            vt[v].exp);
      check($sformatf("vec%0d count", v),    32'(ntok),       32'd8);
      check($sformatf("vec%0d last_idx", v), 32'(last_idx),   32'd7);
      check($sformatf("vec%0d latency", v),  32'(lat),        32'd15);
      check($sformatf("vec%0d drops", v),    32'(drops),      32'd0);
      check($sformatf("vec%0d idle", v),     32'(busy),       32'd0);
    end

    // Level held 3 cycles, then a second edge mid-SEND.
    run_result("hold", 20'h53555, 0, 3, 2, toks, ntok, last_idx, lat, drops);
    check("hold tokens",   toks,          32'h0333A333);
    check("hold count",    32'(ntok),     32'd8);
    check("hold drops",    32'(drops),    32'd1);
    check("hold last_idx", 32'(last_idx), 32'd7);
    ntok = tok_total;
    repeat (20) tick();
    check("hold no_restart busy", 32'(busy),            32'd0);
    check("hold no_restart toks", 32'(tok_total - ntok), 32'd0);

    // Reset during FRAC_CONV.
    res_data  = 20'h02D00;
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    repeat (11) tick();
    check("midrst busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst dig_valid", 32'(dig_valid), 32'd0);
    check("midrst busy",      32'(busy),      32'd0);
    check("midrst dig_data",  32'(dig_data),  32'd0);
    repeat (3) tick();
    check("midrst stays_idle", 32'(busy), 32'd0);
    run_result("midrst", 20'h02D00, 2, 1, -1, toks, ntok, last_idx, lat, drops);
    check("midrst tokens",  toks,        32'h0011A250);
    check("midrst count",   32'(ntok),   32'd8);
    check("midrst latency", 32'(lat),    32'd15);

    // Random results against the arithmetic model.
    for (int n = 0; n < 25; n++) begin
      rd = 20'($urandom);
      run_result($sformatf("rnd%0d", n), rd, 2, int'($urandom_range(1, 3)), -1, toks, ntok, last_idx, lat, drops);
      check($sformatf("rnd%0d tokens d=%0h", n, rd), toks, model(rd));
      check($sformatf("rnd%0d count", n),    32'(ntok),     32'd8);
      check($sformatf("rnd%0d last_idx", n), 32'(last_idx), 32'd7);
      check($sformatf("rnd%0d drops", n),    32'(drops),    32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

endmodule
